// File: rtl/reg_wr_pkg.sv
// Shared types and helpers for the multi-port register-file write decoder.
package reg_wr_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_NREG   = 2**DEF_ADDR_W;

    typedef struct packed {
        logic                  valid;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wr_req_t;

    function automatic logic [DEF_NREG-1:0] onehot(input logic [DEF_ADDR_W-1:0] addr);
        onehot       = '0;
        onehot[addr] = 1'b1;
    endfunction

    // Priority rule: held entries beat live ones, then lower port index wins.
    function automatic logic beats(input logic q_held, input logic p_held,
                                   input int q, input int p);
        beats = (q_held && !p_held) || ((q_held == p_held) && (q < p));
    endfunction

endpackage

// File: rtl/wr_onehot_dec.sv
// Combinational binary to one-hot decoder with a gating enable.
module wr_onehot_dec #(
    parameter int ADDR_W = 4
) (
    input  logic                 en,
    input  logic [ADDR_W-1:0]    addr,
    output logic [2**ADDR_W-1:0] dec
);

    always_comb begin
        for (int i = 0; i < 2**ADDR_W; i++) begin
            dec[i] = en && (addr == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/reg_wr_dec_arb.sv
// Multi-port register write decoder: arbitrates same-address collisions through
// per-port 1-entry skid holds and registers one-hot enables plus per-register data.
module reg_wr_dec_arb
    import reg_wr_pkg::*;
#(
    parameter int                  ADDR_W  = 4,
    parameter int                  NPORT   = 2,
    parameter int                  DATA_W  = 16,
    parameter logic [2**ADDR_W-1:0] RO_MASK = 'h0001,
    parameter int                  CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NPORT-1:0]             wr_valid,
    input  logic [NPORT*ADDR_W-1:0]      wr_addr,
    input  logic [NPORT*DATA_W-1:0]      wr_data,
    output logic [NPORT-1:0]             wr_ready,
    output logic [2**ADDR_W-1:0]         R_en,
    output logic [(2**ADDR_W)*DATA_W-1:0] R_data,
    output logic                         ro_err,
    output logic [CNT_W-1:0]             conflict_cnt
);

    localparam int NREG = 2**ADDR_W;

    logic [NPORT-1:0]             held_valid;
    logic [NPORT-1:0][ADDR_W-1:0] held_addr;
    logic [NPORT-1:0][DATA_W-1:0] held_data;

    logic [NPORT-1:0]             eff_valid;
    logic [NPORT-1:0][ADDR_W-1:0] eff_addr;
    logic [NPORT-1:0][DATA_W-1:0] eff_data;

    logic [NPORT-1:0]             lose;
    logic [NPORT-1:0]             grant;
    logic [NPORT-1:0]             grant_wr;
    logic [NPORT-1:0]             grant_ro;
    logic [NPORT-1:0][NREG-1:0]   dec;

    logic [NREG-1:0]              en_nxt;
    logic [NREG-1:0][DATA_W-1:0]  data_nxt;
    logic                         ro_nxt;

    assign wr_ready = ~held_valid;

    // A held entry masks the live port; the port is not ready while it is held.
    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            eff_valid[p] = held_valid[p] | wr_valid[p];
            eff_addr[p]  = held_valid[p] ? held_addr[p] : wr_addr[p*ADDR_W +: ADDR_W];
            eff_data[p]  = held_valid[p] ? held_data[p] : wr_data[p*DATA_W +: DATA_W];
        end
    end

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        lose = '0;
        for (int p = 0; p < NPORT; p++) begin
            for (int q = 0; q < NPORT; q++) begin
                if (q != p && eff_valid[p] && eff_valid[q] &&
                    eff_addr[q] == eff_addr[p] &&
                    beats(held_valid[q], held_valid[p], q, p)) begin
                    lose[p] = 1'b1;
                end
            end
        end
        grant = eff_valid & ~lose;
        for (int p = 0; p < NPORT; p++) begin
            grant_ro[p] = grant[p] &  RO_MASK[eff_addr[p]];
            grant_wr[p] = grant[p] & ~RO_MASK[eff_addr[p]];
        end
    end

    for (genvar p = 0; p < NPORT; p++) begin : g_dec
        wr_onehot_dec #(.ADDR_W(ADDR_W)) u_dec (
            .en   (grant_wr[p]),
            .addr (eff_addr[p]),
            .dec  (dec[p])
        );
    end

    // Grants never share an address, so OR-merging the gated data is exact.
    always_comb begin
        en_nxt   = '0;
        data_nxt = '0;
        for (int p = 0; p < NPORT; p++) begin
            en_nxt = en_nxt | dec[p];
            for (int i = 0; i < NREG; i++) begin
                data_nxt[i] = data_nxt[i] | ({DATA_W{dec[p][i]}} & eff_data[p]);
            end
        end
        ro_nxt = |grant_ro;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            R_en   <= '0;
            R_data <= '0;
            ro_err <= 1'b0;
        end else begin
            R_en   <= en_nxt;
            R_data <= data_nxt;
            ro_err <= ro_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_valid <= '0;
            held_addr  <= '0;
            held_data  <= '0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                if (lose[p]) begin
                    held_valid[p] <= 1'b1;
                    held_addr[p]  <= eff_addr[p];
                    held_data[p]  <= eff_data[p];
                end else if (grant[p]) begin
                    held_valid[p] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (|lose && conflict_cnt != {CNT_W{1'b1}}) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_wr_dec_arb.sv
// Directed bench for reg_wr_dec_arb; a second instance with a 2-bit counter checks saturation.
module tb_reg_wr_dec_arb;
    import reg_wr_pkg::*;

    localparam int ADDR_W = 4;
    localparam int NPORT  = 2;
    localparam int DATA_W = 16;
    localparam int NREG   = 16;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NPORT-1:0]         wr_valid;
    logic [NPORT*ADDR_W-1:0]  wr_addr;
    logic [NPORT*DATA_W-1:0]  wr_data;
    logic [NPORT-1:0]         wr_ready,  wr_ready2;
    logic [NREG-1:0]          r_en,      r_en2;
    logic [NREG*DATA_W-1:0]   r_data,    r_data2;
    logic                     ro_err,    ro_err2;
    logic [7:0]               cnt;
    logic [1:0]               cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_wr_dec_arb #(.ADDR_W(ADDR_W), .NPORT(NPORT), .DATA_W(DATA_W),
                     .RO_MASK(16'h0001), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready), .R_en(r_en), .R_data(r_data),
        .ro_err(ro_err), .conflict_cnt(cnt)
    );

    reg_wr_dec_arb #(.ADDR_W(ADDR_W), .NPORT(NPORT), .DATA_W(DATA_W),
                     .RO_MASK(16'h0001), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready2), .R_en(r_en2), .R_data(r_data2),
        .ro_err(ro_err2), .conflict_cnt(cnt2)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input wr_req_t r0, input wr_req_t r1);
        wr_valid = {r1.valid, r0.valid};
        wr_addr  = {r1.addr,  r0.addr};
        wr_data  = {r1.data,  r0.data};
    endtask

    task automatic idle();
        drive('0, '0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NREG*DATA_W-1:0] slice(input int i, input logic [DATA_W-1:0] d);
        logic [NREG*DATA_W-1:0] v;
        v = '0;
        v[i*DATA_W +: DATA_W] = d;
        return v;
    endfunction

    function automatic wr_req_t req(input logic [3:0] a, input logic [15:0] d);
        return '{valid: 1'b1, addr: a, data: d};
    endfunction

    initial begin
        rst_n = 1'b0;
        // Requests during reset must be discarded.
        drive(req(4'd5, 16'hDEAD), req(4'd5, 16'hBEEF));
        step(); step();
        idle();
        rst_n = 1'b1;
        step();
        check("rst_en",    r_en,     16'h0000);
        check("rst_data",  r_data,   '0);
        check("rst_cnt",   cnt,      8'd0);
        check("rst_ro",    ro_err,   1'b0);
        check("rst_ready", wr_ready, 2'b11);

        // Single write, one-cycle enable.
        drive(req(4'd5, 16'hABCD), '0);
        step();
        check("w5_en",   r_en,   16'h0020);
        check("w5_data", r_data, slice(5, 16'hABCD));
        idle();
        step();
        check("w5_clear", r_en, 16'h0000);

        // Two ports, distinct addresses.
        drive(req(4'd3, 16'h1111), req(4'd9, 16'h2222));
        step();
        check("w39_en",   r_en,   16'h0208);
        check("w39_data", r_data, slice(3, 16'h1111) | slice(9, 16'h2222));
        check("w39_cnt",  cnt,    8'd0);

        // Same port, back-to-back same address.
        drive(req(4'd4, 16'h0001), '0);
        step();
        check("b2b_en0",   r_en,   16'h0010);
        check("b2b_data0", r_data, slice(4, 16'h0001));
        drive(req(4'd4, 16'h0002), '0);
        step();
        check("b2b_en1",   r_en,   16'h0010);
        check("b2b_data1", r_data, slice(4, 16'h0002));
        idle();

        // Live/live collision on 7: p0 wins, p1 replayed.
        drive(req(4'd7, 16'h1111), req(4'd7, 16'h2222));
        step();
        check("col_en1",    r_en,     16'h0080);
        check("col_data1",  r_data,   slice(7, 16'h1111));
        check("col_ready1", wr_ready, 2'b01);
        check("col_cnt1",   cnt,      8'd1);
        idle();
        step();
        check("col_en2",   r_en,   16'h0080);
        check("col_data2", r_data, slice(7, 16'h2222));
        step();
        check("col_en3",    r_en,     16'h0000);
        check("col_ready3", wr_ready, 2'b11);
        check("col_cnt3",   cnt,      8'd1);

        // Held p1 beats live p0 on the same address.
        drive(req(4'd7, 16'h3333), req(4'd7, 16'h4444));
        step();
        check("hp_data1",  r_data,   slice(7, 16'h3333));
        check("hp_ready1", wr_ready, 2'b01);
        check("hp_cnt1",   cnt,      8'd2);
        drive(req(4'd7, 16'h5555), '0);
        step();
        check("hp_en2",    r_en,     16'h0080);
        check("hp_data2",  r_data,   slice(7, 16'h4444));
        check("hp_ready2", wr_ready, 2'b10);
        check("hp_cnt2",   cnt,      8'd3);
        check("hp_cnt2_w2", cnt2,    2'd3);
        idle();
        step();
        check("hp_data3",  r_data,   slice(7, 16'h5555));
        check("hp_ready3", wr_ready, 2'b11);
        step();
        check("hp_en4",    r_en,     16'h0000);

        // Fourth conflict cycle: 2-bit counter stays saturated.
        drive(req(4'd2, 16'hAAAA), req(4'd2, 16'hBBBB));
        step();
        check("c4_data", r_data, slice(2, 16'hAAAA));
        check("c4_cnt",  cnt,    8'd4);
        check("c4_sat",  cnt2,   2'd3);
        idle();
        step();
        check("c4_replay", r_data, slice(2, 16'hBBBB));

        // Read-only register 0.
        drive(req(4'd0, 16'hFFFF), '0);
        step();
        check("ro_en",   r_en,   16'h0000);
        check("ro_data", r_data, '0);
        check("ro_err1", ro_err, 1'b1);
        idle();
        step();
        check("ro_err0", ro_err, 1'b0);

        // RO collision: both consumed, one per cycle.
        drive(req(4'd0, 16'h1234), req(4'd0, 16'h5678));
        step();
        check("roc_err1",   ro_err,   1'b1);
        check("roc_en1",    r_en,     16'h0000);
        check("roc_ready1", wr_ready, 2'b01);
        check("roc_cnt",    cnt,      8'd5);
        check("roc_sat",    cnt2,     2'd3);
        idle();
        step();
        check("roc_err2",   ro_err,   1'b1);
        check("roc_ready2", wr_ready, 2'b11);
        step();
        check("roc_err3",   ro_err,   1'b0);

        // RO write alongside a normal write to the top register.
        drive(req(4'd0, 16'h0F0F), req(4'd15, 16'h7777));
        step();
        check("mix_en",   r_en,   16'h8000);
        check("mix_data", r_data, slice(15, 16'h7777));
        check("mix_ro",   ro_err, 1'b1);
        idle();
        step();

        // Reset mid-operation with a hold full.
        drive(req(4'd9, 16'hAAAA), req(4'd9, 16'hBBBB));
        step();
        check("mr_ready_pre", wr_ready, 2'b01);
        check("mr_en_pre",    r_en,     16'h0200);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_en",    r_en,     16'h0000);
        check("mr_data",  r_data,   '0);
        check("mr_ready", wr_ready, 2'b11);
        check("mr_cnt",   cnt,      8'd0);
        check("mr_cnt2",  cnt2,     2'd0);
        drive(req(4'd6, 16'h6666), '0);
        step();
        idle();
        rst_n = 1'b1;
        step();
        check("mr_norepl_en", r_en,     16'h0000);
        check("mr_norepl_rd", wr_ready, 2'b11);
        drive(req(4'd1, 16'h0101), '0);
        step();
        check("mr_post_en",  r_en,  16'h0002);
        check("mr_post_en2", r_en2, 16'h0002);
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
